// File: rtl/mem_access_stage.sv
// ============================================================================
// mem_access_stage : MEM pipeline stage with wait-stated internal data memory,
//                    byte/halfword/word lanes, misalignment fault and branch resolve.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_access_stage #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [31:0] ALUResult_In,
    input  logic [31:0] RegisterRead2_In,
    input  logic [31:0] AdderResult_In,
    input  logic        MemRead_In,
    input  logic        MemWrite_In,
    input  logic        Branch_In,
    input  logic        ALUZero_In,
    input  logic [1:0]  MemSize_In,
    input  logic        LoadSigned_In,
    output logic [31:0] ReadData_Out,
    output logic        Stall_Out,
    output logic        PCSrc_Out,
    output logic [31:0] BranchTarget_Out,
    output logic        MisalignFault_Out
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [1:0]    size_q, size_d;
    logic          sgn_q, sgn_d;
    logic          wr_q, wr_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          fault_q, fault_d;

    logic [31:0]   mem_q [DEPTH_WORDS];

    logic          req_w;
    logic          misalign_w;
    logic          issue_w;
    logic          commit_w;
    logic [31:0]   word_w;
    logic [7:0]    byte_w;
    logic [15:0]   half_w;
    logic [31:0]   load_w;
    logic [3:0]    be_w;
    logic [31:0]   wlane_w;
    logic          unused_w;

    // Address bits above the memory span alias onto the same words.
    assign unused_w = ^ALUResult_In[31:AW+2];

    assign req_w      = MemRead_In | MemWrite_In;
    assign misalign_w = ((MemSize_In == 2'b01) & ALUResult_In[0]) |
                        (MemSize_In[1] & (ALUResult_In[1:0] != 2'b00));
    assign issue_w    = (state_q == S_IDLE) & req_w & ~misalign_w;
    assign commit_w   = (state_q == S_WAIT) & (cnt_q == 4'd0);

    assign word_w = mem_q[addr_q[AW+1:2]];
    assign byte_w = word_w[{addr_q[1:0], 3'b000} +: 8];
    assign half_w = addr_q[1] ? word_w[31:16] : word_w[15:0];

    always_comb begin
        load_w  = word_w;
        be_w    = 4'b1111;
        wlane_w = wdata_q;
        case (size_q)
            2'b00: begin
                load_w  = sgn_q ? {{24{byte_w[7]}}, byte_w} : {24'd0, byte_w};
                be_w    = 4'b0001 << addr_q[1:0];
                wlane_w = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                load_w  = sgn_q ? {{16{half_w[15]}}, half_w} : {16'd0, half_w};
                be_w    = addr_q[1] ? 4'b1100 : 4'b0011;
                wlane_w = {2{wdata_q[15:0]}};
            end
            default: begin
                load_w  = word_w;
                be_w    = 4'b1111;
                wlane_w = wdata_q;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        fault_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_w) begin
                    if (misalign_w) begin
                        fault_d = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                        addr_d  = ALUResult_In[AW+1:0];
                        wdata_d = RegisterRead2_In;
                        size_d  = MemSize_In;
                        sgn_d   = LoadSigned_In;
                        wr_d    = MemWrite_In;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                    if (!wr_q) begin
                        rdata_d = load_w;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            size_q  <= 2'd0;
            sgn_q   <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= 32'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    // Array is deliberately not reset; a reset mid-WAIT leaves state IDLE so no commit.
    always_ff @(posedge Clk) begin
        if (commit_w && wr_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_w[i]) begin
                    mem_q[addr_q[AW+1:2]][8*i +: 8] <= wlane_w[8*i +: 8];
                end
            end
        end
    end

    assign ReadData_Out      = rdata_q;
    assign MisalignFault_Out = fault_q;
    assign Stall_Out         = Rst_n & (issue_w | (state_q == S_WAIT));
    assign PCSrc_Out         = Rst_n & Branch_In & ALUZero_In & (state_q == S_IDLE);
    assign BranchTarget_Out  = AdderResult_In;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage against a byte-array memory model.
`default_nettype none

module tb_mem_access_stage;

    localparam int DEPTH = 256;
    localparam int WAITC = 1;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic [31:0] ALUResult_In, RegisterRead2_In, AdderResult_In;
    logic        MemRead_In, MemWrite_In, Branch_In, ALUZero_In;
    logic [1:0]  MemSize_In;
    logic        LoadSigned_In;
    logic [31:0] ReadData_Out, BranchTarget_Out;
    logic        Stall_Out, PCSrc_Out, MisalignFault_Out;

    int errors = 0;
    int checks = 0;

    logic [7:0]  mm [DEPTH*4];
    logic [31:0] exp_rd;

    mem_access_stage #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .ALUResult_In(ALUResult_In), .RegisterRead2_In(RegisterRead2_In),
        .AdderResult_In(AdderResult_In),
        .MemRead_In(MemRead_In), .MemWrite_In(MemWrite_In),
        .Branch_In(Branch_In), .ALUZero_In(ALUZero_In),
        .MemSize_In(MemSize_In), .LoadSigned_In(LoadSigned_In),
        .ReadData_Out(ReadData_Out), .Stall_Out(Stall_Out), .PCSrc_Out(PCSrc_Out),
        .BranchTarget_Out(BranchTarget_Out), .MisalignFault_Out(MisalignFault_Out)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic int unsigned bidx(input logic [31:0] a);
        return a % (DEPTH * 4);
    endfunction

    function automatic bit is_mis(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'b00) return 1'b0;
        if (sz == 2'b01) return a[0];
        return a[1:0] != 2'b00;
    endfunction

    function automatic void model_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        int unsigned b = bidx(a);
        int n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        for (int k = 0; k < n; k++) mm[b + k] = d[8*k +: 8];
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic sgn);
        int unsigned b = bidx(a);
        int n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        longint v = 0;
        for (int k = n - 1; k >= 0; k--) v = (v << 8) + mm[b + k];
        if (sgn && n < 4 && v >= (longint'(1) << (8*n - 1))) v = v - (longint'(1) << (8*n));
        return v[31:0];
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        MemRead_In = 1'b0; MemWrite_In = 1'b0; ALUResult_In = 32'd0;
        RegisterRead2_In = 32'd0; MemSize_In = 2'b10; LoadSigned_In = 1'b0;
    endtask

    // Entered and left one time unit after a rising edge, with the DUT in IDLE.
    task automatic access(input logic wr, input logic rd, input logic [31:0] addr,
                          input logic [31:0] data, input logic [1:0] size, input logic sgn,
                          output logic issue_stall, output int stall_cyc,
                          output logic fault_seen, output logic [31:0] rd_val,
                          output logic fault_late);
        MemWrite_In = wr; MemRead_In = rd; ALUResult_In = addr;
        RegisterRead2_In = data; MemSize_In = size; LoadSigned_In = sgn;
        #1;
        issue_stall = Stall_Out;
        stall_cyc = 0;
        if (!issue_stall) begin
            @(posedge Clk); #1;
            fault_seen = MisalignFault_Out;
            rd_val = ReadData_Out;
            idle_inputs();
            @(posedge Clk); #1;
            fault_late = MisalignFault_Out;
        end else begin
            while (Stall_Out && stall_cyc < 40) begin
                @(posedge Clk); #1;
                stall_cyc++;
            end
            rd_val = ReadData_Out;
            fault_seen = MisalignFault_Out;
            // A misaligned store offered in DONE must be ignored.
            MemWrite_In = 1'b1; MemRead_In = 1'b0; ALUResult_In = addr | 32'h1; MemSize_In = 2'b10;
            @(posedge Clk); #1;
            fault_late = MisalignFault_Out;
            idle_inputs();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        Rst_n = 1'b0;
        MemWrite_In = 1'b1; MemRead_In = 1'b0; ALUResult_In = 32'h10; MemSize_In = 2'b10;
        RegisterRead2_In = 32'h1; LoadSigned_In = 1'b0;
        Branch_In = 1'b1; ALUZero_In = 1'b1; AdderResult_In = 32'h0;
        repeat (2) @(posedge Clk);
        #2;
        checks++; if (ReadData_Out !== 32'd0) begin errors++; $display("FAIL reset_rd: got %h want 00000000", ReadData_Out); end
        checks++; if (Stall_Out !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", Stall_Out); end
        checks++; if (PCSrc_Out !== 1'b0) begin errors++; $display("FAIL reset_pcsrc: got %b want 0", PCSrc_Out); end
        checks++; if (MisalignFault_Out !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", MisalignFault_Out); end
        idle_inputs(); Branch_In = 1'b0; ALUZero_In = 1'b0;
        @(negedge Clk); Rst_n = 1'b1;
        @(posedge Clk); #1;
        exp_rd = 32'd0;
    endtask

    task automatic test_word();
        logic is_, fs, fl; int sc; logic [31:0] rv;
        access(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 2'b10, 1'b1, is_, sc, fs, rv, fl);
        model_store(32'h10, 32'hDEADBEEF, 2'b10);
        checks++; if (is_ !== 1'b1 || sc != WAITC + 1) begin errors++; $display("FAIL word_store_stall: issue=%b cycles=%0d want 1/%0d", is_, sc, WAITC + 1); end
        checks++; if (rv !== exp_rd) begin errors++; $display("FAIL word_store_rd_hold: got %h want %h", rv, exp_rd); end
        checks++; if (fl !== 1'b0) begin errors++; $display("FAIL done_ignored: fault got %b want 0", fl); end
        access(1'b0, 1'b1, 32'h10, 32'h0, 2'b10, 1'b1, is_, sc, fs, rv, fl);
        exp_rd = model_load(32'h10, 2'b10, 1'b1);
        checks++; if (is_ !== 1'b1 || sc != WAITC + 1) begin errors++; $display("FAIL word_load_stall: issue=%b cycles=%0d want 1/%0d", is_, sc, WAITC + 1); end
        checks++; if (rv !== 32'hDEADBEEF || rv !== exp_rd) begin errors++; $display("FAIL word_load: got %h want DEADBEEF", rv); end
    endtask

    task automatic test_byte_lanes();
        logic is_, fs, fl; int sc; logic [31:0] rv;
        access(1'b1, 1'b0, 32'h11, 32'hAAAAAA7F, 2'b00, 1'b0, is_, sc, fs, rv, fl);
        model_store(32'h11, 32'hAAAAAA7F, 2'b00);
        checks++; if (rv !== exp_rd) begin errors++; $display("FAIL byte_store_rd_hold: got %h want %h", rv, exp_rd); end
        access(1'b0, 1'b1, 32'h10, 32'h0, 2'b10, 1'b0, is_, sc, fs, rv, fl);
        exp_rd = model_load(32'h10, 2'b10, 1'b0);
        checks++; if (rv !== 32'hDEAD7FEF) begin errors++; $display("FAIL byte_merge_word: got %h want DEAD7FEF", rv); end
        access(1'b0, 1'b1, 32'h13, 32'h0, 2'b00, 1'b1, is_, sc, fs, rv, fl);
        exp_rd = model_load(32'h13, 2'b00, 1'b1);
        checks++; if (rv !== 32'hFFFFFFDE) begin errors++; $display("FAIL byte_signed: got %h want FFFFFFDE", rv); end
        access(1'b0, 1'b1, 32'h13, 32'h0, 2'b00, 1'b0, is_, sc, fs, rv, fl);
        exp_rd = model_load(32'h13, 2'b00, 1'b0);
        checks++; if (rv !== 32'h000000DE) begin errors++; $display("FAIL byte_unsigned: got %h want 000000DE", rv); end
    endtask

    task automatic test_half_misalign();
        logic is_, fs, fl; int sc; logic [31:0] rv;
        access(1'b0, 1'b1, 32'h12, 32'h0, 2'b01, 1'b1, is_, sc, fs, rv, fl);
        exp_rd = model_load(32'h12, 2'b01, 1'b1);
        checks++; if (rv !== 32'hFFFFDEAD) begin errors++; $display("FAIL half_signed: got %h want FFFFDEAD", rv); end
        access(1'b0, 1'b1, 32'h12, 32'h0, 2'b10, 1'b0, is_, sc, fs, rv, fl);
        checks++; if (is_ !== 1'b0) begin errors++; $display("FAIL misalign_stall: got %b want 0", is_); end
        checks++; if (fs !== 1'b1 || fl !== 1'b0) begin errors++; $display("FAIL misalign_pulse: first=%b next=%b want 1/0", fs, fl); end
        checks++; if (rv !== exp_rd) begin errors++; $display("FAIL misalign_rd_hold: got %h want %h", rv, exp_rd); end
        access(1'b1, 1'b0, 32'h11, 32'h55555555, 2'b01, 1'b0, is_, sc, fs, rv, fl);
        checks++; if (is_ !== 1'b0 || fs !== 1'b1) begin errors++; $display("FAIL misalign_half_store: stall=%b fault=%b want 0/1", is_, fs); end
        access(1'b0, 1'b1, 32'h10, 32'h0, 2'b11, 1'b0, is_, sc, fs, rv, fl);
        exp_rd = model_load(32'h10, 2'b10, 1'b0);
        checks++; if (rv !== exp_rd) begin errors++; $display("FAIL misalign_no_write: got %h want %h", rv, exp_rd); end
    endtask

    task automatic test_branch();
        Branch_In = 1'b1; ALUZero_In = 1'b1; AdderResult_In = 32'h400;
        #1;
        checks++; if (PCSrc_Out !== 1'b1 || BranchTarget_Out !== 32'h400) begin errors++; $display("FAIL branch_idle: pcsrc=%b target=%h want 1/00000400", PCSrc_Out, BranchTarget_Out); end
        ALUZero_In = 1'b0; #1;
        checks++; if (PCSrc_Out !== 1'b0) begin errors++; $display("FAIL branch_not_zero: got %b want 0", PCSrc_Out); end
        ALUZero_In = 1'b1;
        MemWrite_In = 1'b1; ALUResult_In = 32'h30; RegisterRead2_In = 32'h0BADF00D; MemSize_In = 2'b10;
        model_store(32'h30, 32'h0BADF00D, 2'b10);
        #1;
        checks++; if (PCSrc_Out !== 1'b1 || Stall_Out !== 1'b1) begin errors++; $display("FAIL branch_issue: pcsrc=%b stall=%b want 1/1", PCSrc_Out, Stall_Out); end
        @(posedge Clk); #1;
        checks++; if (PCSrc_Out !== 1'b0 || BranchTarget_Out !== 32'h400) begin errors++; $display("FAIL branch_wait: pcsrc=%b target=%h want 0/00000400", PCSrc_Out, BranchTarget_Out); end
        while (Stall_Out) begin @(posedge Clk); #1; end
        idle_inputs();
        @(posedge Clk); #1;
        checks++; if (PCSrc_Out !== 1'b1) begin errors++; $display("FAIL branch_back_idle: got %b want 1", PCSrc_Out); end
        Branch_In = 1'b0; ALUZero_In = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        logic is_, fs, fl; int sc; logic [31:0] rv;
        access(1'b1, 1'b0, 32'h20, 32'hCAFEF00D, 2'b10, 1'b0, is_, sc, fs, rv, fl);
        model_store(32'h20, 32'hCAFEF00D, 2'b10);
        MemWrite_In = 1'b1; ALUResult_In = 32'h20; RegisterRead2_In = 32'h12345678; MemSize_In = 2'b10;
        Branch_In = 1'b1; ALUZero_In = 1'b1;
        @(posedge Clk); #1;
        checks++; if (Stall_Out !== 1'b1) begin errors++; $display("FAIL midwait_in_wait: stall got %b want 1", Stall_Out); end
        Rst_n = 1'b0; #1;
        exp_rd = 32'd0;
        checks++; if (Stall_Out !== 1'b0 || PCSrc_Out !== 1'b0 || ReadData_Out !== 32'd0 || MisalignFault_Out !== 1'b0) begin
            errors++; $display("FAIL midwait_outputs: stall=%b pcsrc=%b rd=%h fault=%b want all 0", Stall_Out, PCSrc_Out, ReadData_Out, MisalignFault_Out);
        end
        @(posedge Clk);
        @(negedge Clk); idle_inputs(); Branch_In = 1'b0; ALUZero_In = 1'b0; Rst_n = 1'b1;
        @(posedge Clk); #1;
        access(1'b0, 1'b1, 32'h20, 32'h0, 2'b10, 1'b0, is_, sc, fs, rv, fl);
        exp_rd = model_load(32'h20, 2'b10, 1'b0);
        checks++; if (rv !== 32'hCAFEF00D) begin errors++; $display("FAIL midwait_aborted: got %h want CAFEF00D", rv); end
    endtask

    task automatic test_alias();
        logic is_, fs, fl; int sc; logic [31:0] rv;
        access(1'b1, 1'b0, 32'h400, 32'h13579BDF, 2'b10, 1'b0, is_, sc, fs, rv, fl);
        model_store(32'h400, 32'h13579BDF, 2'b10);
        access(1'b0, 1'b1, 32'h000, 32'h0, 2'b10, 1'b0, is_, sc, fs, rv, fl);
        exp_rd = model_load(32'h000, 2'b10, 1'b0);
        checks++; if (rv !== 32'h13579BDF) begin errors++; $display("FAIL alias: got %h want 13579BDF", rv); end
    endtask

    task automatic test_back_to_back();
        logic is_, fs, fl; int sc; logic [31:0] rv;
        logic [31:0] a, d; logic [1:0] sz; logic sg, wr, rd; bit mis;
        for (int k = 0; k < 8; k++) begin
            d = $urandom;
            access(1'b1, 1'b0, 32'h40 + 32'(4*k), d, 2'b10, 1'b0, is_, sc, fs, rv, fl);
            model_store(32'h40 + 32'(4*k), d, 2'b10);
        end
        for (int n = 0; n < 80; n++) begin
            a  = ($urandom & 32'hFFFF_FC00) | (32'h40 + 32'($urandom_range(0, 31)));
            d  = $urandom;
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom);
            case ($urandom_range(0, 2))
                0: begin wr = 1'b1; rd = 1'b0; end
                1: begin wr = 1'b0; rd = 1'b1; end
                default: begin wr = 1'b1; rd = 1'b1; end
            endcase
            mis = is_mis(a, sz);
            access(wr, rd, a, d, sz, sg, is_, sc, fs, rv, fl);
            if (mis) begin
                checks++; if (is_ !== 1'b0 || fs !== 1'b1 || fl !== 1'b0 || rv !== exp_rd) begin
                    errors++; $display("FAIL rand_misalign[%0d]: a=%h sz=%0d stall=%b fault=%b/%b rd=%h want 0,1/0,%h", n, a, sz, is_, fs, fl, rv, exp_rd);
                end
            end else begin
                if (wr) model_store(a, d, sz);
                else    exp_rd = model_load(a, sz, sg);
                checks++; if (is_ !== 1'b1 || sc != WAITC + 1 || fs !== 1'b0 || fl !== 1'b0 || rv !== exp_rd) begin
                    errors++; $display("FAIL rand_access[%0d]: wr=%b a=%h sz=%0d sg=%b stall=%b/%0d rd=%h want 1/%0d rd=%h", n, wr, a, sz, sg, is_, sc, rv, WAITC + 1, exp_rd);
                end
            end
        end
    endtask

    initial begin
        idle_inputs();
        Branch_In = 1'b0; ALUZero_In = 1'b0; AdderResult_In = 32'd0;
        exp_rd = 32'd0;
        test_reset();
        test_word();
        test_byte_lanes();
        test_half_misalign();
        test_branch();
        test_reset_mid_wait();
        test_alias();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, meaning number of 32-bit words in internal data memory (power of 2).
REQ-002 Parameter WAIT_CYCLES, default 1, meaning wait states added to every aligned memory access (range 1-15).
REQ-003 Clk  input  1  sole clock; all state updates on posedge.
REQ-004 Rst_n  input  1  asynchronous, active-low reset.
REQ-005 ALUResult_In  input  32  byte address from EX/MEM register.
REQ-006 RegisterRead2_In  input  32  store data.
REQ-007 AdderResult_In  input  32  branch target.
REQ-008 MemRead_In, MemWrite_In, Branch_In, ALUZero_In  input  1 each  control from EX/MEM register.
REQ-009 MemSize_In  input  2  00 byte, 01 halfword, 10 word, 11 treated as word.
REQ-010 LoadSigned_In  input  1  1 sign-extends byte/halfword loads, 0 zero-extends.
REQ-011 ReadData_Out  output  32  registered load result for MEM/WB register.
REQ-012 Stall_Out  output  1  freeze request to PC, IF/ID, ID/EX, EX/MEM registers.
REQ-013 PCSrc_Out  output  1  branch taken; BranchTarget_Out  output  32  redirect address.
REQ-014 MisalignFault_Out  output  1  registered one-cycle fault pulse.

Function
REQ-015 FSM SHALL have states IDLE, WAIT, DONE; transitions: IDLE->WAIT on aligned request, WAIT->DONE when wait counter reaches 0, DONE->IDLE unconditionally.
REQ-016 Request = MemRead_In | MemWrite_In sampled in IDLE only; MemWrite_In has priority when both set (access treated as store, ReadData_Out unchanged).
REQ-017 On IDLE->WAIT the block SHALL latch address, store data, size, sign flag, direction, and load counter with WAIT_CYCLES-1.
REQ-018 Stall_Out SHALL be 1 combinationally in the IDLE cycle with an aligned request and throughout WAIT; 0 in DONE and otherwise -> stall length = WAIT_CYCLES+1 cycles, access completes in cycle WAIT_CYCLES+1.
REQ-019 Store commit and load capture SHALL occur on the WAIT->DONE edge; ReadData_Out then holds the value until the next completed load.
REQ-020 Word index = address bits [log2(DEPTH_WORDS)+1:2]; higher address bits ignored (aliasing wrap).
REQ-021 Little-endian lanes: byte lane = addr[1:0], halfword lane = addr[1]; stores write only selected lanes, other lanes unchanged.
REQ-022 Misaligned = halfword with addr[0]=1 or word with addr[1:0]!=0; SHALL pulse MisalignFault_Out next cycle, no stall, no memory write, ReadData_Out unchanged.
REQ-023 Inputs in DONE SHALL be ignored (upstream advances at end of DONE); no access is re-issued.
REQ-024 PCSrc_Out = Branch_In & ALUZero_In when state is IDLE, forced 0 otherwise; BranchTarget_Out = AdderResult_In combinationally.

Reset
REQ-025 Rst_n low SHALL immediately force state IDLE, counter 0, ReadData_Out 0, MisalignFault_Out 0; Stall_Out and PCSrc_Out follow to 0.
REQ-026 Reset during WAIT SHALL abort the access with no store committed.
REQ-027 Memory array contents SHALL NOT be reset.

Verification
REQ-028 Store word 0xDEADBEEF to 0x10, then load word 0x10, signed -> Stall_Out high 2 cycles each (WAIT_CYCLES=1), ReadData_Out=0xDEADBEEF in DONE.
REQ-029 Store byte 0x7F to 0x11 over prior word, load byte 0x13 signed -> word reads 0xDEAD7FEF; byte 0x13 reads 0xFFFFFFDE; unsigned 0x000000DE.
REQ-030 Load halfword at 0x12 signed from 0xDEAD7FEF -> 0xFFFFDEAD; load word at 0x12 -> MisalignFault_Out pulses 1 cycle, Stall_Out stays 0.
REQ-031 Rst_n low mid-WAIT of store 0x12345678 to 0x20, then load 0x20 -> prior contents returned, not 0x12345678; outputs 0 during reset.
REQ-032 Branch_In=1, ALUZero_In=1, AdderResult_In=0x400 in IDLE -> PCSrc_Out=1, BranchTarget_Out=0x400; same inputs during WAIT -> PCSrc_Out=0.
REQ-033 Store to 0x400 with DEPTH_WORDS=256, load 0x000 -> same data returned (aliasing).
